// File: rtl/click_generator.sv
// Metronome click voice: turns a beat pulse into a timed LED flash and a
// square-wave buzzer tone, higher pitched on the first beat of each bar.
module click_generator #(
    parameter int HALF_PERIOD_ACCENT = 25000,
    parameter int HALF_PERIOD_NORMAL = 50000,
    parameter int CLICK_LEN          = 2500000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_trigger,
    input  logic [2:0] i_beats_per_bar,
    input  logic       i_mute,
    output logic       o_buzzer,
    output logic       o_led,
    output logic       o_accent,
    output logic [2:0] o_beat_index
);

    localparam int HP_MAX = (HALF_PERIOD_ACCENT > HALF_PERIOD_NORMAL) ?
                            HALF_PERIOD_ACCENT : HALF_PERIOD_NORMAL;
    localparam int TW = ($clog2(HP_MAX) > 0) ? $clog2(HP_MAX) : 1;
    localparam int DW = ($clog2(CLICK_LEN) > 0) ? $clog2(CLICK_LEN) : 1;

    localparam logic [TW-1:0] TONE_ACC_END = TW'(HALF_PERIOD_ACCENT - 1);
    localparam logic [TW-1:0] TONE_NRM_END = TW'(HALF_PERIOD_NORMAL - 1);
    localparam logic [DW-1:0] DUR_END      = DW'(CLICK_LEN - 1);

    typedef enum logic {
        IDLE,
        CLICK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] dur_cnt;
    logic [TW-1:0] tone_cnt;
    logic [2:0]    beat_cnt;
    logic          phase;

    logic          dur_end;
    logic          tone_end;
    logic          click_end;
    logic [3:0]    beat_inc;
    logic          beat_wrap;

    assign dur_end   = (dur_cnt == DUR_END);
    assign tone_end  = (tone_cnt == (o_accent ? TONE_ACC_END : TONE_NRM_END));
    assign beat_inc  = {1'b0, beat_cnt} + 4'd1;
    assign beat_wrap = (beat_inc >= {1'b0, i_beats_per_bar});

    always_comb begin
        state_nxt = state;
        click_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_trigger) state_nxt = CLICK;
            end
            CLICK: begin
                if (!i_trigger && dur_end) begin
                    state_nxt = IDLE;
                    click_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // phase keeps running while muted so an unmute lands back on the tone grid
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dur_cnt      <= '0;
            tone_cnt     <= '0;
            beat_cnt     <= '0;
            phase        <= 1'b0;
            o_buzzer     <= 1'b0;
            o_led        <= 1'b0;
            o_accent     <= 1'b0;
            o_beat_index <= '0;
        end else if (i_trigger) begin
            dur_cnt      <= '0;
            tone_cnt     <= '0;
            phase        <= 1'b1;
            o_buzzer     <= ~i_mute;
            o_led        <= 1'b1;
            o_accent     <= (beat_cnt == 3'd0) && (i_beats_per_bar != 3'd0);
            o_beat_index <= beat_cnt;
            beat_cnt     <= beat_wrap ? 3'd0 : beat_inc[2:0];
        end else if (click_end) begin
            dur_cnt  <= '0;
            tone_cnt <= '0;
            phase    <= 1'b0;
            o_buzzer <= 1'b0;
            o_led    <= 1'b0;
            o_accent <= 1'b0;
        end else if (state == CLICK) begin
            dur_cnt <= dur_cnt + 1'b1;
            if (tone_end) begin
                tone_cnt <= '0;
                phase    <= ~phase;
                o_buzzer <= ~phase & ~i_mute;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
                if (i_mute) o_buzzer <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_click_generator.sv
// Self-checking bench for click_generator with short tone/click timing;
// expected beat index/accent per trigger are queued and popped at click start.
module tb_click_generator;

    localparam int HPA = 2;
    localparam int HPN = 4;
    localparam int LEN = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic [2:0] bpb = 3'd4;
    logic       mute = 1'b0;
    logic       buz;
    logic       led;
    logic       acc;
    logic [2:0] idx;

    typedef struct packed {
        logic [2:0] idx;
        logic       acc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [2:0] mb;
    int         checks = 0;
    int         failures = 0;

    click_generator #(
        .HALF_PERIOD_ACCENT(HPA),
        .HALF_PERIOD_NORMAL(HPN),
        .CLICK_LEN(LEN)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_trigger(trig),
        .i_beats_per_bar(bpb),
        .i_mute(mute),
        .o_buzzer(buz),
        .o_led(led),
        .o_accent(acc),
        .o_beat_index(idx)
    );

    always #5 clk = ~clk;

    function automatic logic exp_buz(input int k, input int hp);
        return ((k / hp) % 2) == 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mb = 3'd0;
        q.delete();
        @(negedge clk);
    endtask

    // called at a negedge; returns at the negedge after the sampling edge
    task automatic fire();
        exp_t x;
        x.idx = mb;
        x.acc = (mb == 3'd0) && (bpb != 3'd0);
        q.push_back(x);
        mb = ({1'b0, mb} + 4'd1 >= {1'b0, bpb}) ? 3'd0 : mb + 3'd1;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({buz, led, acc, idx} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async got=%b want=000000", {buz, led, acc, idx});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mb = 3'd0;
        @(negedge clk);
        checks++;
        if ({buz, led, acc, idx} !== 6'b0) begin
            failures++;
            $display("FAIL reset_release got=%b want=000000", {buz, led, acc, idx});
        end
    endtask

    task automatic test_single();
        bpb = 3'd4;
        fire();
        e = q.pop_front();
        checks++;
        if (idx !== e.idx || acc !== e.acc || acc !== 1'b1) begin
            failures++;
            $display("FAIL single_tag got=%0d/%b want=0/1", idx, acc);
        end
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (led !== 1'b1 || buz !== exp_buz(k, HPA)) begin
                failures++;
                $display("FAIL single_wave k=%0d got=%b%b want=1%b",
                         k, led, buz, exp_buz(k, HPA));
            end
            @(negedge clk);
        end
        checks++;
        if ({led, buz, acc} !== 3'b000) begin
            failures++;
            $display("FAIL single_end got=%b want=000", {led, buz, acc});
        end
    endtask

    task automatic test_bar();
        int hp;
        do_reset();
        bpb = 3'd4;
        for (int b = 0; b < 5; b++) begin
            fire();
            e = q.pop_front();
            checks++;
            if (idx !== e.idx || acc !== e.acc) begin
                failures++;
                $display("FAIL bar_tag b=%0d got=%0d/%b want=%0d/%b",
                         b, idx, acc, e.idx, e.acc);
            end
            hp = e.acc ? HPA : HPN;
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (led !== 1'b1 || buz !== exp_buz(k, hp)) begin
                    failures++;
                    $display("FAIL bar_wave b=%0d k=%0d got=%b%b want=1%b",
                             b, k, led, buz, exp_buz(k, hp));
                end
                @(negedge clk);
            end
            checks++;
            if (led !== 1'b0) begin
                failures++;
                $display("FAIL bar_end b=%0d led=%b want=0", b, led);
            end
            repeat (9) @(negedge clk);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        bpb = 3'd4;
        fire();
        e = q.pop_front();
        repeat (10) @(negedge clk);
        checks++;
        if (led !== 1'b1) begin
            failures++;
            $display("FAIL retrig_pre led=%b want=1", led);
        end
        fire();
        e = q.pop_front();
        checks++;
        if (idx !== 3'd1 || idx !== e.idx || acc !== e.acc) begin
            failures++;
            $display("FAIL retrig_tag got=%0d/%b want=1/0", idx, acc);
        end
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (led !== 1'b1 || buz !== exp_buz(k, HPN)) begin
                failures++;
                $display("FAIL retrig_wave k=%0d got=%b%b want=1%b",
                         k, led, buz, exp_buz(k, HPN));
            end
            @(negedge clk);
        end
        checks++;
        if (led !== 1'b0) begin
            failures++;
            $display("FAIL retrig_end led=%b want=0", led);
        end
    endtask

    task automatic test_mute();
        logic want;
        do_reset();
        bpb = 3'd4;
        mute = 1'b1;
        fire();
        e = q.pop_front();
        checks++;
        if (acc !== e.acc || idx !== e.idx) begin
            failures++;
            $display("FAIL mute_tag got=%0d/%b want=%0d/%b", idx, acc, e.idx, e.acc);
        end
        for (int k = 0; k < LEN; k++) begin
            if (k == 5) mute = 1'b0;
            want = (k <= 5) ? 1'b0 : exp_buz(k, HPA);
            checks++;
            if (led !== 1'b1 || buz !== want) begin
                failures++;
                $display("FAIL mute_wave k=%0d got=%b%b want=1%b", k, led, buz, want);
            end
            @(negedge clk);
        end
        checks++;
        if (led !== 1'b0) begin
            failures++;
            $display("FAIL mute_end led=%b want=0", led);
        end
    endtask

    task automatic test_no_accent();
        do_reset();
        bpb = 3'd0;
        for (int b = 0; b < 3; b++) begin
            fire();
            e = q.pop_front();
            checks++;
            if (acc !== 1'b0 || idx !== 3'd0 || idx !== e.idx) begin
                failures++;
                $display("FAIL noacc b=%0d got=%0d/%b want=0/0", b, idx, acc);
            end
            repeat (22) @(negedge clk);
        end
        bpb = 3'd4;
        for (int b = 0; b < 5; b++) begin
            if (b == 3) bpb = 3'd2;
            fire();
            e = q.pop_front();
            checks++;
            if (idx !== e.idx || acc !== e.acc) begin
                failures++;
                $display("FAIL bpb_change b=%0d got=%0d/%b want=%0d/%b",
                         b, idx, acc, e.idx, e.acc);
            end
            repeat (22) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bpb = 3'd4;
        fire();
        e = q.pop_front();
        repeat (22) @(negedge clk);
        fire();
        e = q.pop_front();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({buz, led, acc, idx} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_async got=%b want=000000", {buz, led, acc, idx});
        end
        @(negedge clk);
        rst = 1'b0;
        mb = 3'd0;
        @(negedge clk);
        fire();
        e = q.pop_front();
        checks++;
        if (idx !== 3'd0 || acc !== 1'b1 || led !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_next got=%0d/%b/%b want=0/1/1", idx, acc, led);
        end
    endtask

    initial begin
        mb = 3'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_bar();
        test_retrigger();
        test_mute();
        test_no_accent();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
